// File: rtl/ci_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ci_pkg : shared widths and route-entry type for the custom-instruction
//          dispatcher.          Revision 1.0
// ----------------------------------------------------------------------------
package ci_pkg;

  localparam int CI_FUNC_W = 10;
  localparam int CI_DATA_W = 32;

  typedef struct packed {
    logic       unmapped;
    logic [2:0] idx;
  } route_t;

endpackage : ci_pkg
`default_nettype wire

// File: rtl/ci_route_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ci_route_fifo : synchronous FIFO of route entries, records issue order.
//                 Revision 1.0
// ----------------------------------------------------------------------------
module ci_route_fifo
  import ci_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  route_t push_data,
  input  logic   pop,
  output route_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

  route_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == C_DEPTH);
  assign empty = (count == '0);

endmodule : ci_route_fifo
`default_nettype wire

// File: rtl/ci_dispatch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ci_dispatch : routes CPU custom instructions to accelerator slaves and
//               returns responses in issue order. Optional statistics
//               counters enabled by CI_DISPATCH_STATS_EN.   Revision 1.0
// ----------------------------------------------------------------------------
module ci_dispatch
  import ci_pkg::*;
#(
  parameter int          NUM_TARGETS  = 2,
  parameter int          SEL_LSB      = 7,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] UNMAPPED_RSP = 32'h0000_0000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [CI_FUNC_W-1:0]             cmd_function_id,
  input  logic [CI_DATA_W-1:0]             cmd_inputs_0,
  input  logic [CI_DATA_W-1:0]             cmd_inputs_1,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [CI_DATA_W-1:0]             rsp_outputs_0,
  output logic [NUM_TARGETS-1:0]           t_cmd_valid,
  input  logic [NUM_TARGETS-1:0]           t_cmd_ready,
  output logic [CI_FUNC_W-1:0]             t_cmd_function_id,
  output logic [CI_DATA_W-1:0]             t_cmd_inputs_0,
  output logic [CI_DATA_W-1:0]             t_cmd_inputs_1,
  input  logic [NUM_TARGETS-1:0]           t_rsp_valid,
  output logic [NUM_TARGETS-1:0]           t_rsp_ready,
  input  logic [CI_DATA_W*NUM_TARGETS-1:0] t_rsp_outputs_0
`ifdef CI_DISPATCH_STATS_EN
  ,
  output logic [31:0]                      stat_cmd_count,
  output logic [15:0]                      stat_unmapped_count,
  output logic [31:0]                      stat_stall_cycles
`endif
);

  localparam int SEL_W = CI_FUNC_W - SEL_LSB;

  logic [SEL_W-1:0] sel;
  logic             cmd_mapped;
  logic [2:0]       cmd_idx;
  logic             tgt_ready;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  route_t           push_data;
  route_t           head;

  assign sel               = cmd_function_id[CI_FUNC_W-1:SEL_LSB];
  assign t_cmd_function_id = cmd_function_id;
  assign t_cmd_inputs_0    = cmd_inputs_0;
  assign t_cmd_inputs_1    = cmd_inputs_1;

  always_comb begin
    cmd_mapped = 1'b0;
    cmd_idx    = '0;
    tgt_ready  = 1'b0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      if (int'(sel) == k) begin
        cmd_mapped = 1'b1;
        cmd_idx    = 3'(k);
        tgt_ready  = t_cmd_ready[k];
      end
    end
  end

  // A full FIFO refuses commands even when a pop happens this cycle.
  always_comb begin
    cmd_ready   = !reset && !fifo_full && (cmd_mapped ? tgt_ready : 1'b1);
    t_cmd_valid = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      t_cmd_valid[k] = !reset && cmd_valid && !fifo_full && cmd_mapped
                       && (cmd_idx == 3'(k));
    end
  end

  assign push      = cmd_valid && cmd_ready;
  assign push_data = '{unmapped: !cmd_mapped, idx: cmd_idx};

  ci_route_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_route_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Only the head target sees rsp_ready; early responders elsewhere stall.
  always_comb begin
    rsp_valid     = 1'b0;
    rsp_outputs_0 = '0;
    t_rsp_ready   = '0;
    if (!reset && !fifo_empty) begin
      if (head.unmapped) begin
        rsp_valid     = 1'b1;
        rsp_outputs_0 = UNMAPPED_RSP;
      end else begin
        for (int k = 0; k < NUM_TARGETS; k++) begin
          if (head.idx == 3'(k)) begin
            rsp_valid      = t_rsp_valid[k];
            t_rsp_ready[k] = rsp_ready;
            if (t_rsp_valid[k]) begin
              rsp_outputs_0 = t_rsp_outputs_0[CI_DATA_W*k +: CI_DATA_W];
            end
          end
        end
      end
    end
  end

  assign pop = rsp_valid && rsp_ready;

`ifdef CI_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cmd_count      <= '0;
      stat_unmapped_count <= '0;
      stat_stall_cycles   <= '0;
    end else begin
      if (push && (stat_cmd_count != '1)) begin
        stat_cmd_count <= stat_cmd_count + 1'b1;
      end
      if (push && !cmd_mapped && (stat_unmapped_count != '1)) begin
        stat_unmapped_count <= stat_unmapped_count + 1'b1;
      end
      if (cmd_valid && !cmd_ready && (stat_stall_cycles != '1)) begin
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
      end
    end
  end
`endif

endmodule : ci_dispatch
`default_nettype wire
